// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding selects,
// load-use detection and multiplier sequencing with front-end stall/bubble.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MULT_LAT   = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  id_is_mult,
    input  logic                  id_reads_hilo,
    input  logic                  flush,
    input  logic                  ext_freeze,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic                  bubble,
    output logic                  mult_busy
);

    typedef enum logic {IDLE, BUSY} mstate_t;

    mstate_t               mstate;
    logic [CNT_W-1:0]      mcnt;

    logic [REG_ADDR_W-1:0] ex_rs_p0, ex_rt_p0, ex_rd_p0;
    logic                  ex_urs_p0, ex_urt_p0, ex_rw_p0, ex_ld_p0;
    logic [REG_ADDR_W-1:0] mem_rd_p1;
    logic                  mem_rw_p1;
    logic [REG_ADDR_W-1:0] wb_rd_p2;
    logic                  wb_rw_p2;

    logic load_hz, mult_hz;

    // MEM result wins over WB; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  src_used,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  mem_rw,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_rw
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src_used && mem_rw && (mem_rd != '0) && (mem_rd == src))
            sel = 2'b01;
        else if (src_used && wb_rw && (wb_rd != '0) && (wb_rd == src))
            sel = 2'b10;
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_rs_p0, ex_urs_p0, mem_rd_p1, mem_rw_p1, wb_rd_p2, wb_rw_p2);
    assign fwd_b = fwd_sel(ex_rt_p0, ex_urt_p0, mem_rd_p1, mem_rw_p1, wb_rd_p2, wb_rw_p2);

    assign load_hz = ex_ld_p0 && ex_rw_p0 && (ex_rd_p0 != '0) &&
                     ((id_use_rs && (id_rs == ex_rd_p0)) ||
                      (id_use_rt && (id_rt == ex_rd_p0)));

    assign mult_busy = (mstate == BUSY);
    assign mult_hz   = mult_busy && (id_is_mult || id_reads_hilo);

    // A squashed instruction never needs to wait.
    assign stall  = (load_hz || mult_hz) && !flush;
    assign bubble = stall;

    // ---- ID -> EX -> MEM -> WB shadow pipeline ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs_p0  <= '0;
            ex_rt_p0  <= '0;
            ex_rd_p0  <= '0;
            ex_urs_p0 <= 1'b0;
            ex_urt_p0 <= 1'b0;
            ex_rw_p0  <= 1'b0;
            ex_ld_p0  <= 1'b0;
            mem_rd_p1 <= '0;
            mem_rw_p1 <= 1'b0;
            wb_rd_p2  <= '0;
            wb_rw_p2  <= 1'b0;
        end else if (!ext_freeze) begin
            wb_rd_p2  <= mem_rd_p1;
            wb_rw_p2  <= mem_rw_p1;
            mem_rd_p1 <= ex_rd_p0;
            mem_rw_p1 <= ex_rw_p0;
            ex_rs_p0  <= id_rs;
            ex_rt_p0  <= id_rt;
            ex_rd_p0  <= id_rd;
            ex_urs_p0 <= id_use_rs;
            ex_urt_p0 <= id_use_rt;
            ex_rw_p0  <= id_reg_write && !(bubble || flush);
            ex_ld_p0  <= id_is_load && !(bubble || flush);
        end
    end

    // Multiplier runs independently of the memory freeze once issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate <= IDLE;
            mcnt   <= '0;
        end else begin
            case (mstate)
                IDLE: begin
                    if (id_is_mult && !stall && !flush && !ext_freeze) begin
                        mstate <= BUSY;
                        mcnt   <= CNT_W'(MULT_LAT - 1);
                    end
                end
                BUSY: begin
                    if (mcnt == '0)
                        mstate <= IDLE;
                    else
                        mcnt <= mcnt - CNT_W'(1);
                end
                default: begin
                    mstate <= IDLE;
                    mcnt   <= '0;
                end
            endcase
        end
    end

endmodule
